// File: rtl/mem_pipe_ctrl_pkg.sv
// rtl/mem_pipe_ctrl_pkg.sv - shared header: word size, FSM state encoding, port grant type
//
// Purpose: constants and types shared by mem_pipe_ctrl, its port mux and benches.
// Ports: none (package).
`timescale 1ns/1ps
package mem_pipe_ctrl_pkg;

  localparam int WORD_SIZE = 16;

  // State encoding is public so benches can probe the sequencer state.
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_DATA = 3'd1;
  localparam logic [2:0] ST_INST = 3'd2;
  localparam logic [2:0] ST_STEP = 3'd3;
  localparam logic [2:0] ST_HALT = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_DATA = ST_DATA,
    S_INST = ST_INST,
    S_STEP = ST_STEP,
    S_HALT = ST_HALT
  } state_e;

  // Owner of the single memory port in the current cycle.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_DATA = 2'd1,
    GNT_INST = 2'd2
  } grant_e;

endpackage

// File: rtl/mem_pipe_ctrl_mem_port_mux.sv
// rtl/mem_pipe_ctrl_mem_port_mux.sv - combinational address/strobe/data select for the memory port
//
// Purpose: drives the shared memory port from the MEM-stage or IF-stage request.
// Ports:
//   grant_i                    which requester owns the port (none/data/inst)
//   d_addr_i, d_write_i, d_wdata_i   MEM-stage access
//   i_addr_i                   IF-stage fetch address
//   mem_addr_o, mem_we_o, mem_wdata_o  port outputs (all zero when no grant)
`timescale 1ns/1ps
module mem_port_mux
  import mem_pipe_ctrl_pkg::*;
(
  input  grant_e                 grant_i,
  input  logic [WORD_SIZE-1:0]   d_addr_i,
  input  logic                   d_write_i,
  input  logic [WORD_SIZE-1:0]   d_wdata_i,
  input  logic [WORD_SIZE-1:0]   i_addr_i,
  output logic [WORD_SIZE-1:0]   mem_addr_o,
  output logic                   mem_we_o,
  output logic [WORD_SIZE-1:0]   mem_wdata_o
);

  always_comb begin
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_wdata_o = '0;
    case (grant_i)
      GNT_DATA: begin
        mem_addr_o  = d_addr_i;
        mem_we_o    = d_write_i;
        mem_wdata_o = d_wdata_i;
      end
      GNT_INST: begin
        mem_addr_o  = i_addr_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_pipe_ctrl.sv
// rtl/mem_pipe_ctrl.sv - pipeline step sequencer owning the single-port unified memory
//
// Purpose: per pipeline step, serve the MEM-stage data access, then the IF fetch,
// then pulse all inter-stage register enables for one cycle (load-use qualified).
// Freezes in HALT until reset.
// Ports:
//   clk, reset_n (async, active-low)
//   i_req, i_addr                       IF-stage fetch request
//   d_read, d_write, d_addr, d_wdata    MEM-stage access
//   load_use_hazard, halted             hazard unit / WB halt
//   mem_req, mem_we, mem_addr, mem_wdata, mem_ack, mem_rdata   memory port
//   i_data, d_rdata                     latched fetch / load results
//   PC_Write .. MEM_WB_Write, ID_EX_bubble   pipeline register controls
//   busy                                state != IDLE
`timescale 1ns/1ps
module mem_pipe_ctrl
  import mem_pipe_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_req,
  input  logic [WORD_SIZE-1:0]   i_addr,
  input  logic                   d_read,
  input  logic                   d_write,
  input  logic [WORD_SIZE-1:0]   d_addr,
  input  logic [WORD_SIZE-1:0]   d_wdata,
  input  logic                   load_use_hazard,
  input  logic                   halted,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [WORD_SIZE-1:0]   mem_addr,
  output logic [WORD_SIZE-1:0]   mem_wdata,
  input  logic                   mem_ack,
  input  logic [WORD_SIZE-1:0]   mem_rdata,
  output logic [WORD_SIZE-1:0]   i_data,
  output logic [WORD_SIZE-1:0]   d_rdata,
  output logic                   PC_Write,
  output logic                   IF_ID_Write,
  output logic                   ID_EX_Write,
  output logic                   EX_MEM_Write,
  output logic                   MEM_WB_Write,
  output logic                   ID_EX_bubble,
  output logic                   busy
);

  state_e                 state_q;
  logic [WORD_SIZE-1:0]   i_data_q;
  logic [WORD_SIZE-1:0]   d_rdata_q;
  grant_e                 grant;
  logic                   in_step;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      i_data_q  <= '0;
      d_rdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (halted)                  state_q <= S_HALT;
          else if (d_read || d_write)  state_q <= S_DATA;
          else if (i_req)              state_q <= S_INST;
          else                         state_q <= S_STEP;
        end
        S_DATA: begin
          if (mem_ack) begin
            // A simultaneous read+write is a write: the load latch keeps its value.
            if (d_read && !d_write) d_rdata_q <= mem_rdata;
            state_q <= i_req ? S_INST : S_STEP;
          end
        end
        S_INST: begin
          if (mem_ack) begin
            i_data_q <= mem_rdata;
            state_q  <= S_STEP;
          end
        end
        S_STEP:  state_q <= S_IDLE;
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    grant = GNT_NONE;
    if (state_q == S_DATA)      grant = GNT_DATA;
    else if (state_q == S_INST) grant = GNT_INST;
  end

  mem_port_mux u_port_mux (
    .grant_i     (grant),
    .d_addr_i    (d_addr),
    .d_write_i   (d_write),
    .d_wdata_i   (d_wdata),
    .i_addr_i    (i_addr),
    .mem_addr_o  (mem_addr),
    .mem_we_o    (mem_we),
    .mem_wdata_o (mem_wdata)
  );

  // Moore decode of state; only the PC/IF_ID enables and the bubble see the hazard.
  assign in_step      = (state_q == S_STEP);
  assign mem_req      = (grant != GNT_NONE);
  assign PC_Write     = in_step && !load_use_hazard;
  assign IF_ID_Write  = in_step && !load_use_hazard;
  assign ID_EX_Write  = in_step;
  assign EX_MEM_Write = in_step;
  assign MEM_WB_Write = in_step;
  assign ID_EX_bubble = in_step && load_use_hazard;
  assign busy         = (state_q != S_IDLE);
  assign i_data       = i_data_q;
  assign d_rdata      = d_rdata_q;

endmodule

// File: tb/tb_mem_pipe_ctrl.sv
// tb/tb_mem_pipe_ctrl.sv - scoreboard bench for mem_pipe_ctrl with a behavioural memory model
`timescale 1ns/1ps
module tb_mem_pipe_ctrl;
  import mem_pipe_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic i_req = 0, d_read = 0, d_write = 0, load_use_hazard = 0, halted = 0;
  logic [15:0] i_addr = 0, d_addr = 0, d_wdata = 0;
  logic mem_req, mem_we, mem_ack = 0;
  logic [15:0] mem_addr, mem_wdata, mem_rdata = 0, i_data, d_rdata;
  logic PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write, MEM_WB_Write, ID_EX_bubble, busy;

  always #5 clk = ~clk;

  mem_pipe_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .load_use_hazard(load_use_hazard), .halted(halted),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .i_data(i_data), .d_rdata(d_rdata),
    .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .ID_EX_Write(ID_EX_Write),
    .EX_MEM_Write(EX_MEM_Write), .MEM_WB_Write(MEM_WB_Write),
    .ID_EX_bubble(ID_EX_bubble), .busy(busy)
  );

  typedef struct { logic we; logic [15:0] addr; logic [15:0] wdata; } acc_t;
  typedef struct { logic [5:0] en; logic [15:0] idata; logic [15:0] drdata; } step_t;
  typedef struct { bit dr; bit dw; bit ir; bit hz; logic [15:0] da; logic [15:0] dwd;
                   logic [15:0] ia; int wd; int wi; } stim_t;

  acc_t  exp_acc[$];
  step_t exp_step[$];
  int    wait_q[$];
  logic [15:0] resp_mem [256];
  logic [15:0] model_mem [256];
  logic [15:0] model_idata = 0, model_drdata = 0;
  int errors = 0, checks = 0;
  bit mon_en = 0;

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  // Memory responder: waits for each access come from wait_q (in access order);
  // stray acks with garbage data are thrown in whenever no request is pending.
  int resp_left = 0;
  bit resp_active = 0;
  always @(negedge clk) begin
    if (!reset_n) begin
      mem_ack = 0;
      resp_active = 0;
    end else if (mem_req) begin
      if (!resp_active) begin
        resp_active = 1;
        resp_left = (wait_q.size() != 0) ? wait_q.pop_front() : 0;
      end
      if (resp_left == 0) begin
        mem_ack = 1;
        mem_rdata = resp_mem[mem_addr[7:0]];
        if (mem_we) resp_mem[mem_addr[7:0]] = mem_wdata;
        resp_active = 0;
      end else begin
        mem_ack = 0;
        mem_rdata = 16'($urandom);
        resp_left--;
      end
    end else begin
      mem_ack = ($urandom_range(0, 3) == 0);
      mem_rdata = 16'($urandom);
      resp_active = 0;
    end
  end

  // Monitor: compares completed accesses and step pulses against the scoreboard.
  always @(negedge clk) begin
    acc_t a;
    step_t s;
    #1;
    if (reset_n && mon_en) begin
      if (!mem_req) chk("we_without_req", {15'd0, mem_we}, 16'd0);
      if (mem_req && mem_ack) begin
        if (exp_acc.size() == 0) begin
          checks++; errors++;
          $display("FAIL acc_unexpected: got addr %h expected no access", mem_addr);
        end else begin
          a = exp_acc.pop_front();
          chk("acc_we", {15'd0, mem_we}, {15'd0, a.we});
          chk("acc_addr", mem_addr, a.addr);
          if (a.we) chk("acc_wdata", mem_wdata, a.wdata);
        end
      end
      if (EX_MEM_Write) begin
        if (exp_step.size() == 0) begin
          checks++; errors++;
          $display("FAIL step_unexpected: got enables expected none");
        end else begin
          s = exp_step.pop_front();
          chk("step_enables", {10'd0, PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write,
                               MEM_WB_Write, ID_EX_bubble}, {10'd0, s.en});
          chk("step_i_data", i_data, s.idata);
          chk("step_d_rdata", d_rdata, s.drdata);
        end
      end
    end
  end

  function automatic stim_t mk(bit dr, bit dw, bit ir, bit hz, logic [15:0] da,
                               logic [15:0] dwd, logic [15:0] ia, int wd, int wi);
    stim_t c;
    c.dr = dr; c.dw = dw; c.ir = ir; c.hz = hz;
    c.da = da; c.dwd = dwd; c.ia = ia; c.wd = wd; c.wi = wi;
    return c;
  endfunction

  // Reference model: one step = optional data access, optional fetch, then the enable pulse.
  task automatic run_step(stim_t c);
    acc_t a;
    step_t s;
    int len, cyc;
    bit has_d;
    has_d = c.dr || c.dw;
    if (has_d) begin
      a.we = c.dw; a.addr = c.da; a.wdata = c.dwd;
      exp_acc.push_back(a);
      wait_q.push_back(c.wd);
      if (c.dw) model_mem[c.da[7:0]] = c.dwd;
      else      model_drdata = model_mem[c.da[7:0]];
    end
    if (c.ir) begin
      a.we = 0; a.addr = c.ia; a.wdata = 0;
      exp_acc.push_back(a);
      wait_q.push_back(c.wi);
      model_idata = model_mem[c.ia[7:0]];
    end
    s.en = c.hz ? 6'b001111 : 6'b111110;
    s.idata = model_idata;
    s.drdata = model_drdata;
    exp_step.push_back(s);
    len = 2 + (has_d ? 1 + c.wd : 0) + (c.ir ? 1 + c.wi : 0);

    d_read = c.dr; d_write = c.dw; d_addr = c.da; d_wdata = c.dwd;
    i_req = c.ir; i_addr = c.ia; load_use_hazard = c.hz;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!EX_MEM_Write && cyc < 100);
    if (!EX_MEM_Write) begin
      checks++; errors++;
      $display("FAIL step_timeout: got no step after %0d cycles expected %0d", cyc, len);
      finish_run();
    end
    chk("step_len", 16'(cyc), 16'(len));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] v;
    for (int i = 0; i < 256; i++) begin
      v = 16'($urandom);
      resp_mem[i] = v;
      model_mem[i] = v;
    end
    resp_mem[8'h10] = 16'h6A01; model_mem[8'h10] = 16'h6A01;
    resp_mem[8'h20] = 16'hBEEF; model_mem[8'h20] = 16'hBEEF;

    #1;
    chk("rst_mem_req", {15'd0, mem_req}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_i_data", i_data, 16'd0);
    chk("rst_d_rdata", d_rdata, 16'd0);
    chk("rst_mem_addr", mem_addr, 16'd0);
    chk("rst_mem_wdata", mem_wdata, 16'd0);
    chk("rst_enables", {9'd0, mem_we, PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write,
                        MEM_WB_Write, ID_EX_bubble}, 16'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1;

    // Reset while a load waits for its ack.
    d_read = 1; d_addr = 16'h0020;
    wait_q.push_back(10);
    repeat (3) @(negedge clk);
    chk("mid_req_before_reset", {15'd0, mem_req}, 16'd1);
    reset_n = 0;
    #1;
    chk("mid_req_after_reset", {15'd0, mem_req}, 16'd0);
    chk("mid_busy_after_reset", {15'd0, busy}, 16'd0);
    chk("mid_d_rdata", d_rdata, 16'd0);
    d_read = 0; d_addr = 0;
    wait_q.delete();
    @(posedge clk);
    #1 reset_n = 1;
    mon_en = 1;

    run_step(mk(0, 0, 1, 0, 16'h0000, 16'h0000, 16'h0010, 0, 0));
    run_step(mk(0, 1, 1, 0, 16'h0040, 16'h1234, 16'h0011, 2, 2));
    run_step(mk(1, 0, 0, 1, 16'h0020, 16'h0000, 16'h0000, 0, 0));
    run_step(mk(1, 1, 1, 0, 16'h0021, 16'h5555, 16'h0021, 1, 0));
    run_step(mk(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0));
    run_step(mk(1, 0, 1, 0, 16'h0040, 16'h0000, 16'h0040, 0, 3));

    for (int n = 0; n < 150; n++) begin
      run_step(mk($urandom_range(0, 1), $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) == 0, 16'($urandom_range(0, 31)), 16'($urandom),
                  16'($urandom_range(0, 31)), $urandom_range(0, 3), $urandom_range(0, 3)));
    end

    chk("acc_queue_empty", 16'(exp_acc.size()), 16'd0);
    chk("step_queue_empty", 16'(exp_step.size()), 16'd0);

    // Halt sampled in IDLE; the machine then freezes despite pending requests.
    halted = 1; i_req = 1; d_read = 1; d_addr = 16'h0005; i_addr = 16'h0006;
    @(negedge clk);
    chk("halt_idle_busy", {15'd0, busy}, 16'd0);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      #1;
      chk("halt_frozen", {9'd0, busy, mem_req, PC_Write, IF_ID_Write, ID_EX_Write,
                          EX_MEM_Write, MEM_WB_Write}, 16'h0040);
    end
    finish_run();
  end

endmodule

// File: doc/mem_pipe_ctrl.md
# mem_pipe_ctrl

Sequencer for the 5-stage pipeline that owns the single-port unified memory. Each pipeline step, it arbitrates the shared port between the MEM-stage data access and the IF-stage instruction fetch. It then releases all inter-stage registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) for exactly one cycle. It also applies load-use stalls and freezes the machine on halt.

## Interface
- WORD_SIZE, 16 (shared header): data/address width.
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- i_req  in  1  IF stage needs an instruction this step
- i_addr  in  WORD_SIZE  fetch address (PC)
- d_read  in  1  EX/MEM MemRead
- d_write  in  1  EX/MEM MemWrite
- d_addr  in  WORD_SIZE  EX/MEM ALU result
- d_wdata  in  WORD_SIZE  store data
- load_use_hazard  in  1  from hazard unit
- halted  in  1  halt op reached WB
- mem_req  out  1  port request, held until ack
- mem_we  out  1  write strobe, valid with mem_req
- mem_addr  out  WORD_SIZE  port address
- mem_wdata  out  WORD_SIZE  port write data
- mem_ack  in  1  access complete (read data valid same cycle)
- mem_rdata  in  WORD_SIZE  port read data
- i_data  out  WORD_SIZE  latched instruction
- d_rdata  out  WORD_SIZE  latched load data
- PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write, MEM_WB_Write  out  1 each  register enables
- ID_EX_bubble  out  1  load ID/EX with NOP controls
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, DATA, INST, STEP, HALT.
- IDLE: samples inputs.
  - halted → HALT.
  - Else d_read|d_write → DATA.
  - Else i_req → INST.
  - Else → STEP.
- DATA:
  - mem_req=1, mem_addr=d_addr, mem_we=d_write, mem_wdata=d_wdata.
  - On mem_ack: if d_read, d_rdata←mem_rdata.
  - Then → INST if i_req, else → STEP.
- INST:
  - mem_req=1, mem_addr=i_addr, mem_we=0.
  - On mem_ack: i_data←mem_rdata, → STEP.
- STEP:
  - All five write enables = 1 for one cycle, then → IDLE.
  - If load_use_hazard: PC_Write=0, IF_ID_Write=0, ID_EX_bubble=1; other enables stay 1.
- HALT: all enables 0, mem_req 0, busy 1. Exit only by reset.
- Data access is always served before fetch within a step (older instruction first).
- d_read and d_write both high: treated as write; d_rdata unchanged.
- mem_ack outside DATA/INST is ignored.
- Pipeline inputs are stable while the enables are 0, so no input capture is needed.

## Timing
- Reset (async): state IDLE. All outputs 0, including i_data, d_rdata, mem_addr, mem_wdata.
- Reset mid-access: mem_req drops immediately. The memory must abandon the access, and no latch update occurs.
- Outputs are a Moore decode of state. Exceptions are mem_addr/mem_we/mem_wdata, which mux from inputs during DATA/INST, and the hazard qualifiers in STEP.
- mem_req stays asserted, with address stable, every cycle of DATA/INST until mem_ack. Zero-wait ack (same cycle as state entry) is legal.
- Step length, with ack on the first request cycle:
  - fetch + data: 4 cycles (IDLE, DATA, INST, STEP)
  - fetch only: 3 cycles
  - neither: 2 cycles
  - each wait cycle adds 1
- i_data/d_rdata update on the clock edge where mem_ack=1 and hold until the next ack for the same requester.
- halted is sampled only in IDLE. A step in progress completes first.

## Structure
- WORD_SIZE comes from the shared opcodes header.
- FSM state encoding (3-bit localparams) goes in the shared header as well, so benches can probe state.
- One natural sub-module: mem_port_mux (combinational select of addr/we/wdata by grant).

## Test plan
- Reset, then i_req=1, i_addr=0x0010, mem_ack on the first req cycle, rdata=0x6A01:
  - i_data=0x6A01
  - all enables pulse in cycle 3
  - mem_we never 1
- d_write=1, d_addr=0x0040, d_wdata=0x1234, i_req=1, ack after 2 wait cycles each:
  - write issued first with we=1
  - then fetch
  - STEP in cycle 8
- d_read=1 with rdata=0xBEEF, plus load_use_hazard=1 in STEP:
  - d_rdata=0xBEEF
  - PC_Write=IF_ID_Write=0, ID_EX_bubble=1
  - EX_MEM_Write=MEM_WB_Write=1
- reset_n low while in DATA awaiting ack:
  - mem_req=0 same cycle
  - state IDLE
  - d_rdata stays 0
- halted=1 in IDLE:
  - HALT reached next cycle
  - enables stay 0 and mem_req 0 for 20 cycles despite i_req=1
- d_read=d_write=1:
  - mem_we=1
  - d_rdata unchanged
